// File: rtl/round_tally.sv
// -----------------------------------------------------------------------------
// round_tally
//   Match scorekeeper placed after the baccarat round state machine. It watches
//   the player/dealer win lights and treats each rising edge of (P | D) as one
//   finished round: both lights = tie, P only = player win, D only = dealer win.
//   It keeps saturating per-outcome counters and runs a first-to-TARGET_WINS
//   match FSM (PLAY / OVER) that drives the match-result LED/HEX feed.
//
// Parameters
//   CNT_W        width of every counter; counters saturate at 2**CNT_W-1
//   TARGET_WINS  wins (either side) that end the match, 1..2**CNT_W-1
//
// Build option
//   TALLY_STREAK_EN  defined  : streak / streak_owner tracking present
//                    undefined: no streak registers, both outputs tied to 0
//
// Ports
//   slow_clock        in   1      clock, all state updates on posedge
//   resetb            in   1      synchronous, active-low reset
//   player_win_light  in   1      player win light (both high = tie)
//   dealer_win_light  in   1      dealer win light
//   new_match         in   1      1-cycle pulse: clear counters, start new match
//   player_wins       out  CNT_W  rounds won by player this match
//   dealer_wins       out  CNT_W  rounds won by dealer this match
//   ties              out  CNT_W  tied rounds this match
//   rounds            out  CNT_W  total classified rounds this match
//   streak            out  CNT_W  consecutive wins by streak_owner
//   streak_owner      out  2      00 none, 01 player, 10 dealer
//   match_over        out  1      high while the FSM is in OVER
//   match_winner      out  2      00 none, 01 player, 10 dealer
// -----------------------------------------------------------------------------
module round_tally #(
  parameter int CNT_W       = 8,
  parameter int TARGET_WINS = 5
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             player_win_light,
  input  logic             dealer_win_light,
  input  logic             new_match,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] rounds,
  output logic [CNT_W-1:0] streak,
  output logic [1:0]       streak_owner,
  output logic             match_over,
  output logic [1:0]       match_winner
);

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TARGET     = CNT_W'(TARGET_WINS);
  localparam logic [1:0]       OWN_NONE   = 2'b00;
  localparam logic [1:0]       OWN_PLAYER = 2'b01;
  localparam logic [1:0]       OWN_DEALER = 2'b10;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic             r_lights_q;
  logic [CNT_W-1:0] r_player_wins;
  logic [CNT_W-1:0] r_dealer_wins;
  logic [CNT_W-1:0] r_ties;
  logic [CNT_W-1:0] r_rounds;
  logic             r_match_over;
  logic [1:0]       r_match_winner;

  logic             w_lights;
  logic             w_evt;
  logic             w_tie;
  logic             w_player_only;
  logic [CNT_W-1:0] w_player_next;
  logic [CNT_W-1:0] w_dealer_next;

  // One event per rising edge of the OR of the lights; a held light counts once.
  assign w_lights      = player_win_light | dealer_win_light;
  assign w_evt         = w_lights & ~r_lights_q;
  assign w_tie         = player_win_light & dealer_win_light;
  assign w_player_only = player_win_light & ~dealer_win_light;
  assign w_player_next = sat_inc(r_player_wins);
  assign w_dealer_next = sat_inc(r_dealer_wins);

  // ---------------------------------------------------------------------------
  // Match FSM and tally counters. The winning increment and the move to OVER
  // land on the same edge, so the target compare uses the post-increment value.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with <= so all of them update from the
  // same pre-edge values; blocking = would let later lines see half-updated state.
  always_ff @(posedge slow_clock) begin
    // NOTE: reset is synchronous and every register (there is no memory array)
    // gets an explicit reset value, so outputs are defined from the first edge.
    if (!resetb) begin
      r_state        <= ST_PLAY;
      r_lights_q     <= 1'b0;
      r_player_wins  <= '0;
      r_dealer_wins  <= '0;
      r_ties         <= '0;
      r_rounds       <= '0;
      r_match_over   <= 1'b0;
      r_match_winner <= OWN_NONE;
    end else begin
      // Edge detector keeps sampling even across new_match so a light that is
      // still high afterwards does not re-trigger.
      r_lights_q <= w_lights;
      if (new_match) begin
        r_state        <= ST_PLAY;
        r_player_wins  <= '0;
        r_dealer_wins  <= '0;
        r_ties         <= '0;
        r_rounds       <= '0;
        r_match_over   <= 1'b0;
        r_match_winner <= OWN_NONE;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (w_evt) begin
              r_rounds <= sat_inc(r_rounds);
              if (w_tie) begin
                r_ties <= sat_inc(r_ties);
              end else if (w_player_only) begin
                r_player_wins <= w_player_next;
                if (w_player_next == TARGET) begin
                  r_state        <= ST_OVER;
                  r_match_over   <= 1'b1;
                  r_match_winner <= OWN_PLAYER;
                end
              end else begin
                r_dealer_wins <= w_dealer_next;
                if (w_dealer_next == TARGET) begin
                  r_state        <= ST_OVER;
                  r_match_over   <= 1'b1;
                  r_match_winner <= OWN_DEALER;
                end
              end
            end
          end
          ST_OVER: begin
            // Counters frozen; only new_match leaves this state.
          end
          default: r_state <= ST_PLAY;
        endcase
      end
    end
  end

  assign player_wins  = r_player_wins;
  assign dealer_wins  = r_dealer_wins;
  assign ties         = r_ties;
  assign rounds       = r_rounds;
  assign match_over   = r_match_over;
  assign match_winner = r_match_winner;

`ifdef TALLY_STREAK_EN
  // ---------------------------------------------------------------------------
  // Streak tracking: follows exactly the rounds the FSM accepts.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_streak;
  logic [1:0]       r_streak_owner;
  logic             w_accept;
  logic [1:0]       w_round_winner;

  assign w_accept       = w_evt & ~new_match & (r_state == ST_PLAY);
  assign w_round_winner = w_player_only ? OWN_PLAYER : OWN_DEALER;

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_streak       <= '0;
      r_streak_owner <= OWN_NONE;
    end else if (new_match) begin
      r_streak       <= '0;
      r_streak_owner <= OWN_NONE;
    end else if (w_accept) begin
      if (w_tie) begin
        r_streak       <= '0;
        r_streak_owner <= OWN_NONE;
      end else if (w_round_winner == r_streak_owner) begin
        r_streak <= sat_inc(r_streak);
      end else begin
        r_streak       <= CNT_W'(1);
        r_streak_owner <= w_round_winner;
      end
    end
  end

  assign streak       = r_streak;
  assign streak_owner = r_streak_owner;
`else
  assign streak       = '0;
  assign streak_owner = OWN_NONE;
`endif

endmodule

// File: tb/tb_round_tally.sv
// -----------------------------------------------------------------------------
// tb_round_tally
//   Directed bench for round_tally. Two instances share the clock: u_dut
//   (CNT_W=8, TARGET_WINS=3) and u_sat (CNT_W=2, TARGET_WINS=3) for saturation.
//   Each cycle a behavioural model computes the expected outputs of both
//   instances from the inputs being driven; those are pushed to scoreboard
//   queues and popped after the following posedge to compare against the DUTs.
// -----------------------------------------------------------------------------
module tb_round_tally;

  typedef struct {
    int lq;
    int pw;
    int dw;
    int ties;
    int rounds;
    int streak;
    int owner;
    int over;
    int winner;
  } model_t;

  logic       slow_clock = 1'b0;
  logic       resetb;

  // Main instance
  logic       p, d, nm;
  logic [7:0] pw, dw, tc, rc, sk;
  logic [1:0] so, mw;
  logic       mo;

  // Saturation instance
  logic       sp, sd, snm;
  logic [1:0] s_pw, s_dw, s_tc, s_rc, s_sk;
  logic [1:0] s_so, s_mw;
  logic       s_mo;

  int     n_checks = 0;
  int     n_errors = 0;
  string  phase    = "init";
  model_t m_main;
  model_t m_sat;
  model_t q_main[$];
  model_t q_sat[$];

  always #5 slow_clock = ~slow_clock;

  round_tally #(.CNT_W(8), .TARGET_WINS(3)) u_dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .player_win_light(p),
    .dealer_win_light(d),
    .new_match       (nm),
    .player_wins     (pw),
    .dealer_wins     (dw),
    .ties            (tc),
    .rounds          (rc),
    .streak          (sk),
    .streak_owner    (so),
    .match_over      (mo),
    .match_winner    (mw)
  );

  round_tally #(.CNT_W(2), .TARGET_WINS(3)) u_sat (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .player_win_light(sp),
    .dealer_win_light(sd),
    .new_match       (snm),
    .player_wins     (s_pw),
    .dealer_wins     (s_dw),
    .ties            (s_tc),
    .rounds          (s_rc),
    .streak          (s_sk),
    .streak_owner    (s_so),
    .match_over      (s_mo),
    .match_winner    (s_mw)
  );

  // Reference behaviour of one edge, written from the outcome rules.
  function automatic model_t model_step(model_t m, bit rst_n, bit lp, bit ld,
                                        bit lnm, int maxv, int target);
    model_t n;
    bit     evt;
    int     win;
    n = m;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    evt  = (lp || ld) && (m.lq == 0);
    n.lq = (lp || ld) ? 1 : 0;
    if (lnm) begin
      n.pw = 0; n.dw = 0; n.ties = 0; n.rounds = 0;
      n.streak = 0; n.owner = 0; n.over = 0; n.winner = 0;
      return n;
    end
    if (evt && m.over == 0) begin
      n.rounds = (m.rounds < maxv) ? m.rounds + 1 : maxv;
      if (lp && ld) begin
        n.ties   = (m.ties < maxv) ? m.ties + 1 : maxv;
        n.streak = 0;
        n.owner  = 0;
      end else begin
        win = lp ? 1 : 2;
        if (win == 1) n.pw = (m.pw < maxv) ? m.pw + 1 : maxv;
        else          n.dw = (m.dw < maxv) ? m.dw + 1 : maxv;
        if (win == m.owner) begin
          n.streak = (m.streak < maxv) ? m.streak + 1 : maxv;
        end else begin
          n.streak = 1;
          n.owner  = win;
        end
        if (((win == 1) ? n.pw : n.dw) == target) begin
          n.over   = 1;
          n.winner = win;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s [%s]: observed %0d expected %0d", tag, phase, obs, exp);
    end
  endtask

  task automatic compare(input string who, input model_t e,
                         input logic [31:0] o_pw, input logic [31:0] o_dw,
                         input logic [31:0] o_tc, input logic [31:0] o_rc,
                         input logic [31:0] o_sk, input logic [31:0] o_so,
                         input logic [31:0] o_mo, input logic [31:0] o_mw);
    check({who, ".player_wins"},  o_pw, e.pw);
    check({who, ".dealer_wins"},  o_dw, e.dw);
    check({who, ".ties"},         o_tc, e.ties);
    check({who, ".rounds"},       o_rc, e.rounds);
`ifdef TALLY_STREAK_EN
    check({who, ".streak"},       o_sk, e.streak);
    check({who, ".streak_owner"}, o_so, e.owner);
`else
    check({who, ".streak"},       o_sk, 0);
    check({who, ".streak_owner"}, o_so, 0);
`endif
    check({who, ".match_over"},   o_mo, e.over);
    check({who, ".match_winner"}, o_mw, e.winner);
  endtask

  // One clock: predict from the inputs now on the pins, let the edge happen,
  // then compare the predictions against what the DUTs show.
  task automatic tick();
    model_t e_main;
    model_t e_sat;
    m_main = model_step(m_main, resetb, p, d, nm, 255, 3);
    m_sat  = model_step(m_sat, resetb, sp, sd, snm, 3, 3);
    q_main.push_back(m_main);
    q_sat.push_back(m_sat);
    @(posedge slow_clock);
    #1;
    e_main = q_main.pop_front();
    e_sat  = q_sat.pop_front();
    compare("main", e_main, pw, dw, tc, rc, sk, so, mo, mw);
    compare("sat", e_sat, s_pw, s_dw, s_tc, s_rc, s_sk, s_so, s_mo, s_mw);
  endtask

  task automatic pulse(input logic lp, input logic ld);
    p = lp; d = ld; tick();
    p = 0;  d = 0;  tick();
  endtask

  task automatic spulse(input logic lp, input logic ld);
    sp = lp; sd = ld; tick();
    sp = 0;  sd = 0;  tick();
  endtask

  task automatic start_match();
    nm = 1; snm = 1; tick();
    nm = 0; snm = 0; tick();
  endtask

  initial begin
    m_main = '{default: 0};
    m_sat  = '{default: 0};
    resetb = 0; p = 0; d = 0; nm = 0; sp = 0; sd = 0; snm = 0;
    @(negedge slow_clock);

    phase = "reset";
    tick(); tick();
    resetb = 1;
    tick();

    phase = "t1_single_p";
    p = 1; tick();
    check("t1.player_wins", pw, 1);
    check("t1.rounds", rc, 1);
`ifdef TALLY_STREAK_EN
    check("t1.streak", sk, 1);
    check("t1.streak_owner", so, 2'b01);
`endif
    p = 0; tick();

    phase = "t2_mixed";
    start_match();
    pulse(1, 0); pulse(1, 0); pulse(1, 1); pulse(0, 1);
    check("t2.player_wins", pw, 2);
    check("t2.dealer_wins", dw, 1);
    check("t2.ties", tc, 1);
    check("t2.rounds", rc, 4);
`ifdef TALLY_STREAK_EN
    check("t2.streak", sk, 1);
    check("t2.streak_owner", so, 2'b10);
`endif

    phase = "t3_held";
    start_match();
    p = 1;
    for (int i = 0; i < 5; i++) tick();
    p = 0; tick();
    check("t3.player_wins", pw, 1);

    phase = "t4_target";
    start_match();
    pulse(0, 1); pulse(0, 1); pulse(0, 1);
    check("t4.match_over", mo, 1);
    check("t4.match_winner", mw, 2'b10);
    pulse(0, 1);
    check("t4.frozen_dealer", dw, 3);
    check("t4.frozen_rounds", rc, 3);
    nm = 1; tick(); nm = 0;
    check("t4.cleared_over", mo, 0);
    check("t4.cleared_dealer", dw, 0);
    pulse(1, 0);
    check("t4.play_again", pw, 1);

    phase = "t5_nm_collide";
    start_match();
    p = 1; nm = 1; tick();
    nm = 0; tick(); tick();
    p = 0; tick();
    check("t5.player_wins", pw, 0);
    check("t5.rounds", rc, 0);

    phase = "reset_mid_round";
    pulse(1, 0);
    p = 1; resetb = 0; tick();
    resetb = 1; tick();
    check("rst.player_wins", pw, 1);
    p = 0; tick();

    phase = "t6_saturate";
    start_match();
    for (int i = 0; i < 5; i++) spulse(1, 1);
    check("t6.ties", s_tc, 3);
    check("t6.rounds", s_rc, 3);
    check("t6.match_over", s_mo, 0);

    phase = "t6_max_target";
    start_match();
    spulse(0, 1); spulse(0, 1); spulse(0, 1);
    check("t6.max_dealer", s_dw, 3);
    check("t6.max_over", s_mo, 1);
    check("t6.max_winner", s_mw, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
